// File: rtl/types_pkg.sv
// Shared types for the pipeline control path: controller states, register
// address and data-bus types, and the bundled stall/flush control word.
package types_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [31:0]               DATA_BUS;
    typedef logic [REG_ADDR_WIDTH-1:0] REG_ADDR;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } PIPE_CTRL;

    function automatic DATA_BUS sat_inc(input DATA_BUS value, input logic en);
        if (en && (value != 32'hFFFF_FFFF)) begin
            return value + 32'd1;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/pipeline_controller_load_use_detect.sv
// Load-use hazard compare: a load in execute whose destination feeds the
// instruction in decode. Writes to x0 never create a dependency.
module load_use_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      LoadE_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    output logic                      LoadUse_o
);

    assign LoadUse_o = LoadE_i && (RdE_i != {REG_ADDR_WIDTH{1'b0}}) &&
                       ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the pipeline registers: load-use and branch
// handling, memory-wait freeze with timeout, and saturating event counters.
module pipeline_controller #(
    parameter int MEM_TIMEOUT    = 255,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
    input  logic                      LoadE_i,
    input  logic                      PCSrcE_i,
    input  logic                      MemReqM_i,
    input  logic                      MemReadyM_i,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      StallE_o,
    output logic                      StallM_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic                      FlushW_o,
    output logic                      MemBusy_o,
    output logic                      MemTimeout_o,
    output types_pkg::DATA_BUS        StallCount_o,
    output types_pkg::DATA_BUS        FlushCount_o
);

    import types_pkg::*;

    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    pipe_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc_s;
    DATA_BUS           stall_cnt_q, stall_cnt_d;
    DATA_BUS           flush_cnt_q, flush_cnt_d;
    PIPE_CTRL          ctrl_s, ctrl_out_s;
    logic              loaduse_s;
    logic              memstall_s;

    load_use_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_load_use_detect (
        .LoadE_i   (LoadE_i),
        .RdE_i     (RdE_i),
        .Rs1D_i    (Rs1D_i),
        .Rs2D_i    (Rs2D_i),
        .LoadUse_o (loaduse_s)
    );

    assign memstall_s = MemReqM_i && !MemReadyM_i;

    // Next state, wait count and priority-encoded stall/flush word.
    always_comb begin
        state_d    = state_q;
        wait_d     = {WAIT_W{1'b0}};
        ctrl_s     = '0;
        // The first stalled cycle counts as 1 even while still in RUN.
        wait_inc_s = (state_q == MEM_WAIT) ? (wait_q + WAIT_W'(1)) : WAIT_W'(1);
        case (state_q)
            ERROR: begin
                ctrl_s  = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
                            flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b1};
                state_d = ERROR;
            end
            RUN, MEM_WAIT: begin
                if (memstall_s) begin
                    ctrl_s = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
                               flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b1};
                    wait_d = wait_inc_s;
                    if (wait_inc_s == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = ERROR;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else if (PCSrcE_i) begin
                    ctrl_s.flush_d = 1'b1;
                    ctrl_s.flush_e = 1'b1;
                    state_d        = RUN;
                end else if (loaduse_s) begin
                    ctrl_s.stall_f = 1'b1;
                    ctrl_s.stall_d = 1'b1;
                    ctrl_s.flush_e = 1'b1;
                    state_d        = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // While reset is held the pipeline is filled with bubbles.
    always_comb begin
        if (!rst_n) begin
            ctrl_out_s = '{stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0, stall_m: 1'b0,
                           flush_d: 1'b1, flush_e: 1'b1, flush_w: 1'b1};
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign stall_cnt_d = sat_inc(stall_cnt_q, ctrl_s.stall_f);
    assign flush_cnt_d = sat_inc(flush_cnt_q, ctrl_s.flush_d | ctrl_s.flush_e);

    // Controller state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= {WAIT_W{1'b0}};
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallF_o     = ctrl_out_s.stall_f;
    assign StallD_o     = ctrl_out_s.stall_d;
    assign StallE_o     = ctrl_out_s.stall_e;
    assign StallM_o     = ctrl_out_s.stall_m;
    assign FlushD_o     = ctrl_out_s.flush_d;
    assign FlushE_o     = ctrl_out_s.flush_e;
    assign FlushW_o     = ctrl_out_s.flush_w;
    assign MemBusy_o    = (state_q == MEM_WAIT);
    assign MemTimeout_o = (state_q == ERROR);
    assign StallCount_o = stall_cnt_q;
    assign FlushCount_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller (MEM_TIMEOUT=4): a vector table checked through
// a scoreboard queue, plus hand-written reset sequences.
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D_i, Rs2D_i, RdE_i;
    logic        LoadE_i, PCSrcE_i, MemReqM_i, MemReadyM_i;
    logic        StallF_o, StallD_o, StallE_o, StallM_o;
    logic        FlushD_o, FlushE_o, FlushW_o;
    logic        MemBusy_o, MemTimeout_o;
    logic [31:0] StallCount_o, FlushCount_o;

    pipeline_controller #(
        .MEM_TIMEOUT    (4),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rs1D_i       (Rs1D_i),
        .Rs2D_i       (Rs2D_i),
        .RdE_i        (RdE_i),
        .LoadE_i      (LoadE_i),
        .PCSrcE_i     (PCSrcE_i),
        .MemReqM_i    (MemReqM_i),
        .MemReadyM_i  (MemReadyM_i),
        .StallF_o     (StallF_o),
        .StallD_o     (StallD_o),
        .StallE_o     (StallE_o),
        .StallM_o     (StallM_o),
        .FlushD_o     (FlushD_o),
        .FlushE_o     (FlushE_o),
        .FlushW_o     (FlushW_o),
        .MemBusy_o    (MemBusy_o),
        .MemTimeout_o (MemTimeout_o),
        .StallCount_o (StallCount_o),
        .FlushCount_o (FlushCount_o)
    );

    always #5 clk = ~clk;

    // Control word order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_LU   = 7'b110_0010;
    localparam logic [6:0] C_BR   = 7'b000_0110;
    localparam logic [6:0] C_MEM  = 7'b111_1001;
    localparam logic [6:0] C_RST  = 7'b000_0111;

    typedef struct {
        logic       ld;
        logic [4:0] rd, rs1, rs2;
        logic       pc, req, rdy;
        logic [6:0] ctrl;
        logic       busy, tmo;
    } vec_t;

    typedef struct {
        logic [6:0]  ctrl;
        logic        busy, tmo;
        logic [31:0] sc, fc;
        int          idx;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vt[26];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_sc   = 32'd0;
    logic [31:0] m_fc   = 32'd0;

    function automatic vec_t mk(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic pc, input logic req,
                                input logic rdy, input logic [6:0] ctrl, input logic busy,
                                input logic tmo);
        vec_t v;
        v.ld = ld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.pc = pc; v.req = req; v.rdy = rdy;
        v.ctrl = ctrl; v.busy = busy; v.tmo = tmo;
        return v;
    endfunction

    function automatic logic [6:0] ctrl_now();
        return {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        LoadE_i = v.ld; RdE_i = v.rd; Rs1D_i = v.rs1; Rs2D_i = v.rs2;
        PCSrcE_i = v.pc; MemReqM_i = v.req; MemReadyM_i = v.rdy;
    endtask

    // Drive one vector for one cycle and queue its expected outputs.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.ctrl = v.ctrl; e.busy = v.busy; e.tmo = v.tmo;
        e.sc = m_sc; e.fc = m_fc; e.idx = idx;
        sb_q.push_back(e);
        if (v.ctrl[6]) m_sc = m_sc + 32'd1;
        if (v.ctrl[2] || v.ctrl[1]) m_fc = m_fc + 32'd1;
    endtask

    // Compare queued expectations in the low phase, away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk($sformatf("v%0d ctrl", mon_e.idx), {25'd0, ctrl_now()}, {25'd0, mon_e.ctrl});
            chk($sformatf("v%0d busy", mon_e.idx), {31'd0, MemBusy_o}, {31'd0, mon_e.busy});
            chk($sformatf("v%0d timeout", mon_e.idx), {31'd0, MemTimeout_o}, {31'd0, mon_e.tmo});
            chk($sformatf("v%0d stall_cnt", mon_e.idx), StallCount_o, mon_e.sc);
            chk($sformatf("v%0d flush_cnt", mon_e.idx), FlushCount_o, mon_e.fc);
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, " ctrl"}, {25'd0, ctrl_now()}, {25'd0, C_RST});
        chk({tag, " busy"}, {31'd0, MemBusy_o}, 32'd0);
        chk({tag, " timeout"}, {31'd0, MemTimeout_o}, 32'd0);
        chk({tag, " stall_cnt"}, StallCount_o, 32'd0);
        chk({tag, " flush_cnt"}, FlushCount_o, 32'd0);
    endtask

    initial begin
        vec_t idle_v, ms_v;
        idle_v = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
        ms_v   = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM,  1'b0, 1'b0);
        //           ld    rd     rs1    rs2    pc    req   rdy   ctrl    busy  tmo
        vt[0]  = idle_v;
        vt[1]  = mk(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 1'b0);
        vt[2]  = idle_v;
        vt[3]  = mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
        vt[4]  = mk(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, C_BR,   1'b0, 1'b0);
        vt[5]  = idle_v;
        vt[6]  = mk(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0);
        vt[8]  = ms_v;
        vt[9]  = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM,  1'b1, 1'b0);
        vt[10] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM,  1'b1, 1'b0);
        vt[11] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, C_NONE, 1'b1, 1'b0);
        vt[12] = idle_v;
        vt[13] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, C_MEM,  1'b0, 1'b0);
        vt[14] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, C_MEM,  1'b1, 1'b0);
        vt[15] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, C_BR,   1'b1, 1'b0);
        vt[16] = idle_v;
        vt[17] = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM,  1'b0, 1'b0);
        vt[18] = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, C_LU,   1'b1, 1'b0);
        vt[19] = idle_v;
        vt[20] = ms_v;
        vt[21] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM,  1'b1, 1'b0);
        vt[22] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM,  1'b1, 1'b0);
        vt[23] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM,  1'b1, 1'b0);
        vt[24] = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_MEM,  1'b0, 1'b1);
        vt[25] = mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, C_MEM,  1'b0, 1'b1);

        rst_n = 1'b0;
        drive(idle_v);
        #3;
        chk_reset_state("reset");
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            apply(vt[i], i);
        end
        @(negedge clk);
        #1;

        // ERROR is left only through reset.
        chk("error sticky", {31'd0, MemTimeout_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("reset from error");
        m_sc = 32'd0;
        m_fc = 32'd0;
        drive(idle_v);
        @(negedge clk);
        rst_n = 1'b1;
        apply(idle_v, 100);

        // Asynchronous reset in the middle of a memory wait.
        apply(ms_v, 101);
        apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 1'b1, 1'b0), 102);
        @(posedge clk);
        #2;
        chk("busy before mid-wait reset", {31'd0, MemBusy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid-wait reset");
        m_sc = 32'd0;
        m_fc = 32'd0;
        drive(idle_v);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply(idle_v, 103);

        @(negedge clk);
        #1;
        chk("scoreboard drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
